// File: rtl/wb_forward.sv
// Writeback/bypass stage: holds one pending register-file write, forwards it onto
// the operand read path, and stalls issue on load-use and load/ALU collisions.
//
// state | meaning
// IDLE  | no load in flight; ALU results captured directly
// LOAD  | load data arrives on mem_data this cycle, destination in ld_pend
module wb_forward #(
  parameter int pw = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [pw:0]   alu_addr,
  input  logic [7:0]    alu_data,
  input  logic          ld_valid,
  input  logic [pw:0]   ld_addr,
  input  logic [7:0]    mem_data,
  input  logic [pw:0]   rd_addrA,
  input  logic [pw:0]   rd_addrB,
  input  logic [7:0]    regA_in,
  input  logic [7:0]    regB_in,
  output logic          wr_en,
  output logic [pw:0]   wr_addr,
  output logic [7:0]    dat_out,
  output logic [7:0]    datA_out,
  output logic [7:0]    datB_out,
  output logic          stall
);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t      state, state_nxt;
  logic [pw:0] ld_pend, ld_pend_nxt;
  logic        wb_valid, wb_valid_nxt;
  logic [pw:0] wb_addr, wb_addr_nxt;
  logic [7:0]  wb_data, wb_data_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ld_pend  <= '0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      state    <= state_nxt;
      ld_pend  <= ld_pend_nxt;
      wb_valid <= wb_valid_nxt;
      wb_addr  <= wb_addr_nxt;
      wb_data  <= wb_data_nxt;
    end
  end

  always_comb begin
    stall = (state == LOAD) &&
            (alu_valid || (ld_pend != '0 && (rd_addrA == ld_pend || rd_addrB == ld_pend)));
  end

  always_comb begin
    state_nxt    = state;
    ld_pend_nxt  = ld_pend;
    wb_valid_nxt = 1'b0;
    wb_addr_nxt  = wb_addr;
    wb_data_nxt  = wb_data;
    case (state)
      IDLE: begin
        if (ld_valid) begin
          state_nxt   = LOAD;
          ld_pend_nxt = ld_addr;
        end
        if (alu_valid && alu_addr != '0) begin
          wb_valid_nxt = 1'b1;
          wb_addr_nxt  = alu_addr;
          wb_data_nxt  = alu_data;
        end
      end
      LOAD: begin
        // Load data is captured even when stalled; the held request replays next cycle.
        if (ld_pend != '0) begin
          wb_valid_nxt = 1'b1;
          wb_addr_nxt  = ld_pend;
          wb_data_nxt  = mem_data;
        end
        if (!stall && ld_valid) begin
          ld_pend_nxt = ld_addr;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_en   = wb_valid;
  assign wr_addr = wb_addr;
  assign dat_out = wb_data;

  always_comb begin
    if (rd_addrA == '0)
      datA_out = 8'h00;
    else if (wb_valid && wb_addr == rd_addrA)
      datA_out = wb_data;
    else
      datA_out = regA_in;

    if (rd_addrB == '0)
      datB_out = 8'h00;
    else if (wb_valid && wb_addr == rd_addrB)
      datB_out = wb_data;
    else
      datB_out = regB_in;
  end

endmodule

// File: tb/tb_wb_forward.sv
// Directed bench for wb_forward: reset, ALU forwarding, load-use stall, collisions,
// back-to-back loads and register-0 handling.
module tb_wb_forward;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_valid, ld_valid;
  logic [3:0] alu_addr, ld_addr, rd_addrA, rd_addrB;
  logic [7:0] alu_data, mem_data, regA_in, regB_in;
  logic       wr_en, stall;
  logic [3:0] wr_addr;
  logic [7:0] dat_out, datA_out, datB_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_forward #(.pw(3)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .mem_data(mem_data),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .regA_in(regA_in), .regB_in(regB_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .dat_out(dat_out),
    .datA_out(datA_out), .datB_out(datB_out), .stall(stall)
  );

  // Advance to just after the next rising edge; inputs set afterwards belong to the new cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    ld_valid = 0; ld_addr = 0; mem_data = 0;
    rd_addrA = 0; rd_addrB = 0; regA_in = 0; regB_in = 0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    rd_addrA = 4'd2; regA_in = 8'h33;
    rd_addrB = 4'd0; regB_in = 8'h44;
    #3;
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    tests++; if (wr_addr !== 4'd0) begin fails++; $display("FAIL reset_wr_addr got %h want 0", wr_addr); end
    tests++; if (dat_out !== 8'h00) begin fails++; $display("FAIL reset_dat_out got %h want 00", dat_out); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
    tests++; if (datA_out !== 8'h33) begin fails++; $display("FAIL reset_datA got %h want 33", datA_out); end
    tests++; if (datB_out !== 8'h00) begin fails++; $display("FAIL reset_datB_r0 got %h want 00", datB_out); end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_reset_mid_load();
    clear_inputs();
    ld_valid = 1; ld_addr = 4'd5;
    cyc();
    ld_valid = 0; mem_data = 8'h9E;
    alu_valid = 1; alu_addr = 4'd7; alu_data = 8'h01;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL midload_pre_stall got %b want 1", stall); end
    reset = 1'b1;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL midload_rst_stall got %b want 0", stall); end
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL midload_rst_wr_en got %b want 0", wr_en); end
    alu_valid = 0;
    #1;
    reset = 1'b0;
    cyc();
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL midload_no_write got wr_en %b addr %h want 0", wr_en, wr_addr); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL midload_after_stall got %b want 0", stall); end
    idle(1);
  endtask

  task automatic test_alu_forward();
    clear_inputs();
    alu_valid = 1; alu_addr = 4'd3; alu_data = 8'h5A;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL alu_n_stall got %b want 0", stall); end
    cyc();
    alu_valid = 0;
    rd_addrA = 4'd3; regA_in = 8'h00;
    rd_addrB = 4'd3; regB_in = 8'h12;
    #1;
    tests++; if (datA_out !== 8'h5A) begin fails++; $display("FAIL alu_fwd_A got %h want 5A", datA_out); end
    tests++; if (datB_out !== 8'h5A) begin fails++; $display("FAIL alu_fwd_B got %h want 5A", datB_out); end
    tests++; if (wr_en !== 1'b1) begin fails++; $display("FAIL alu_wr_en got %b want 1", wr_en); end
    tests++; if (wr_addr !== 4'd3) begin fails++; $display("FAIL alu_wr_addr got %h want 3", wr_addr); end
    tests++; if (dat_out !== 8'h5A) begin fails++; $display("FAIL alu_dat_out got %h want 5A", dat_out); end
    cyc();
    regA_in = 8'h99;
    #1;
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL alu_pulse got %b want 0", wr_en); end
    tests++; if (datA_out !== 8'h99) begin fails++; $display("FAIL alu_nofwd_A got %h want 99", datA_out); end
    idle(1);
  endtask

  task automatic test_load_use();
    clear_inputs();
    ld_valid = 1; ld_addr = 4'd4;
    cyc();
    ld_valid = 0; mem_data = 8'hC3;
    rd_addrB = 4'd4; regB_in = 8'h00;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall got %b want 1", stall); end
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL lu_n1_wr_en got %b want 0", wr_en); end
    cyc();
    mem_data = 8'h00;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_n2_stall got %b want 0", stall); end
    tests++; if (datB_out !== 8'hC3) begin fails++; $display("FAIL lu_fwd_B got %h want C3", datB_out); end
    tests++; if (wr_en !== 1'b1) begin fails++; $display("FAIL lu_wr_en got %b want 1", wr_en); end
    tests++; if (wr_addr !== 4'd4) begin fails++; $display("FAIL lu_wr_addr got %h want 4", wr_addr); end
    idle(1);
    // Same hazard through the A port.
    ld_valid = 1; ld_addr = 4'd9;
    cyc();
    ld_valid = 0; rd_addrA = 4'd9;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall_A got %b want 1", stall); end
    idle(2);
  endtask

  task automatic test_load_alu_collision();
    clear_inputs();
    ld_valid = 1; ld_addr = 4'd2;
    cyc();
    ld_valid = 0; mem_data = 8'h22;
    alu_valid = 1; alu_addr = 4'd6; alu_data = 8'h11;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL col_stall got %b want 1", stall); end
    cyc();
    mem_data = 8'h00;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL col_n2_stall got %b want 0", stall); end
    tests++; if ({wr_en, wr_addr, dat_out} !== {1'b1, 4'd2, 8'h22})
      begin fails++; $display("FAIL col_wr_load got en %b addr %h data %h want 1 2 22", wr_en, wr_addr, dat_out); end
    cyc();
    alu_valid = 0;
    #1;
    tests++; if ({wr_en, wr_addr, dat_out} !== {1'b1, 4'd6, 8'h11})
      begin fails++; $display("FAIL col_wr_alu got en %b addr %h data %h want 1 6 11", wr_en, wr_addr, dat_out); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    ld_valid = 1; ld_addr = 4'd1;
    cyc();
    ld_addr = 4'd2; mem_data = 8'hAA;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL b2b_n1_stall got %b want 0", stall); end
    cyc();
    ld_valid = 0; mem_data = 8'hBB;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL b2b_n2_stall got %b want 0", stall); end
    tests++; if ({wr_en, wr_addr, dat_out} !== {1'b1, 4'd1, 8'hAA})
      begin fails++; $display("FAIL b2b_wr1 got en %b addr %h data %h want 1 1 AA", wr_en, wr_addr, dat_out); end
    cyc();
    mem_data = 8'h00;
    #1;
    tests++; if ({wr_en, wr_addr, dat_out} !== {1'b1, 4'd2, 8'hBB})
      begin fails++; $display("FAIL b2b_wr2 got en %b addr %h data %h want 1 2 BB", wr_en, wr_addr, dat_out); end
    cyc();
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL b2b_end got %b want 0", wr_en); end
    idle(1);
  endtask

  task automatic test_reg_zero();
    clear_inputs();
    alu_valid = 1; alu_addr = 4'd0; alu_data = 8'hFF;
    cyc();
    alu_valid = 0;
    rd_addrA = 4'd0; regA_in = 8'h77;
    #1;
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL r0_alu_wr_en got %b want 0", wr_en); end
    tests++; if (datA_out !== 8'h00) begin fails++; $display("FAIL r0_datA got %h want 00", datA_out); end
    cyc();
    ld_valid = 1; ld_addr = 4'd0;
    cyc();
    ld_valid = 0; mem_data = 8'h55; rd_addrA = 4'd0;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL r0_load_stall got %b want 0", stall); end
    cyc();
    mem_data = 8'h00;
    #1;
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL r0_load_wr_en got %b want 0", wr_en); end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
    test_alu_forward();
    test_load_use();
    test_load_alu_collision();
    test_back_to_back();
    test_reg_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_forward.md
# wb_forward

Writeback and bypass stage placed directly upstream of the register file. It collects ALU results and one-cycle-latency data-memory load results and holds one pending write. It drives the register file write port (data, enable, address) and forwards that pending write onto the operand read path so consumers never see stale data. It also detects load-use hazards and signals a stall to the issue logic.

## Interface
- pw, default 3: register address width is pw+1 bits, matching the register file address ports.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_addr  in  pw+1  ALU destination register.
- alu_data  in  8  ALU result.
- ld_valid  in  1  load issued this cycle; its data arrives on mem_data in the following cycle.
- ld_addr  in  pw+1  load destination register.
- mem_data  in  8  data memory read data.
- rd_addrA, rd_addrB  in  pw+1 each  operand read addresses, the same values presented to the register file.
- regA_in, regB_in  in  8 each  raw register file read data.
- wr_en  out  1  register file write enable.
- wr_addr  out  pw+1  register file write address.
- dat_out  out  8  register file write data (connects to the register file dat_in).
- datA_out, datB_out  out  8 each  forwarded operand data.
- stall  out  1  upstream must hold all inputs stable and re-present them next cycle.

## Operation
- Pending-write register: wb_valid, wb_addr, wb_data.
  - wr_en = wb_valid, wr_addr = wb_addr, dat_out = wb_data, all driven directly from flops.
- Register 0 is constant zero:
  - A capture whose destination is 0 leaves wb_valid=0 (the write is dropped).
  - datA_out = 0 whenever rd_addrA == 0. The same rule applies to B.
- Forwarding is combinational:
  - datA_out = wb_data if wb_valid && wb_addr == rd_addrA && rd_addrA != 0; otherwise regA_in.
  - The same rule applies to B.
- FSM states are IDLE and LOAD. A saved register ld_pend holds the destination of the load in flight.
  - IDLE: if ld_valid, go to LOAD and save ld_pend = ld_addr. If alu_valid, capture the ALU result into the pending-write register in the same edge. Both may occur in one cycle. If neither is valid, wb_valid=0 next cycle.
  - LOAD, not stalled: capture mem_data with destination ld_pend into the pending-write register. Then, if ld_valid, stay in LOAD and save ld_pend = ld_addr (back-to-back loads). Otherwise go to IDLE.
- stall = (state == LOAD) && (alu_valid || (ld_pend != 0 && (rd_addrA == ld_pend || rd_addrB == ld_pend))).
- While stall is high:
  - alu_valid and ld_valid are ignored.
  - The mem_data capture still happens and the FSM goes to IDLE.
  - The held ALU op and operand reads are then accepted in the next cycle, when forwarding covers the load result.
- A load to register 0 still occupies its LOAD cycle. It causes no stall and no write.

## Timing
- Reset, asynchronous: state=IDLE, ld_pend=0, wb_valid=0, wb_addr=0, wb_data=0. Therefore wr_en=0, wr_addr=0, dat_out=0, stall=0. datA_out and datB_out follow regA_in and regB_in (0 for address 0).
- Reset asserted mid-LOAD discards the load; no write occurs.
- ALU path: alu_valid in cycle N gives wr_en high in N+1, the register file updated at the N+2 edge, and the result forwarded during N+1.
- Load path: ld_valid in cycle N, mem_data sampled at the end of N+1, wr_en high in N+2, register file updated at the N+3 edge. A dependent read in N+1 stalls exactly one cycle.
- wb_valid is a one-cycle pulse per accepted result. There is no buffering beyond one entry, and none is needed.
- stall is purely combinational from the current inputs and state. It has no registered latency.

## Test plan
- Reset mid-LOAD: ld_valid addr 5 in cycle N, reset pulsed in N+1 -> wr_en stays 0, state IDLE, stall 0, no write to register 5.
- ALU forward: alu_valid, addr 3, data 0x5A in cycle N; rd_addrA=3 in N+1 with regA_in=0x00 -> datA_out=0x5A, wr_en=1, wr_addr=3, dat_out=0x5A in N+1.
- Load-use: ld_valid addr 4 in cycle N, mem_data=0xC3 in N+1, rd_addrB=4 in N+1 -> stall=1 in N+1; in N+2 stall=0, datB_out=0xC3, wr_en=1, wr_addr=4.
- Load with ALU collision: ld_valid addr 2 in N; alu_valid addr 6 data 0x11 held through N+1 and N+2 -> stall=1 in N+1; writes are reg 2 in N+2 and reg 6 (0x11) in N+3.
- Back-to-back loads: ld_valid addr 1 in N and addr 2 in N+1, mem_data 0xAA then 0xBB, no dependent reads -> writes are (1,0xAA) in N+2 and (2,0xBB) in N+3, with no stall.
- Register 0: alu_valid addr 0 data 0xFF -> wr_en stays 0. rd_addrA=0 with regA_in=0x77 -> datA_out=0x00. A load to addr 0 with rd_addrA=0 -> stall=0.
